// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Control/datapath bundle between multicycle_ctrl and its datapath
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      instr;
    logic [4:0]       status;
    logic             pc_en;
    logic             pcsrc;
    logic             alusrc;
    logic [3:0]       aluop;
    logic             memrw;
    logic             wb;
    logic             regrw;
    logic [1:0]       immgen_ctrl;
    logic             halt;
    logic             done;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr, status,
        output pc_en, pcsrc, alusrc, aluop, memrw, wb, regrw,
               immgen_ctrl, halt, done, state, retired
    );

    modport slave (
        output run, instr, status,
        input  pc_en, pcsrc, alusrc, aluop, memrw, wb, regrw,
               immgen_ctrl, halt, done, state, retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I-subset datapath
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [2:0] c_CLS_R   = 3'd0;
    localparam logic [2:0] c_CLS_I   = 3'd1;
    localparam logic [2:0] c_CLS_LD  = 3'd2;
    localparam logic [2:0] c_CLS_ST  = 3'd3;
    localparam logic [2:0] c_CLS_BR  = 3'd4;
    localparam logic [2:0] c_CLS_BAD = 3'd7;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_SLL = 4'b0101;
    localparam logic [3:0] c_OP_SRL = 4'b0110;
    localparam logic [3:0] c_OP_SRA = 4'b0111;
    localparam logic [3:0] c_OP_SLT = 4'b1000;

    // Only opcode, funct3 and bit 30 steer control: packed as {b30, funct3, opcode}
    function automatic logic [4:0] f_alu(input logic [10:0] fld, input logic is_r);
        logic [2:0] f3;
        logic       b30;
        f3  = fld[9:7];
        b30 = fld[10];
        case (f3)
            3'b000:  f_alu = {1'b1, (is_r && b30) ? c_OP_SUB : c_OP_ADD};
            3'b001:  f_alu = {1'b1, c_OP_SLL};
            3'b010:  f_alu = {1'b1, c_OP_SLT};
            3'b100:  f_alu = {1'b1, c_OP_XOR};
            3'b101:  f_alu = {1'b1, b30 ? c_OP_SRA : c_OP_SRL};
            3'b110:  f_alu = {1'b1, c_OP_OR};
            3'b111:  f_alu = {1'b1, c_OP_AND};
            default: f_alu = {1'b0, c_OP_ADD};
        endcase
    endfunction

    function automatic logic [2:0] f_class(input logic [10:0] fld);
        logic [4:0] alu_r;
        logic [4:0] alu_i;
        alu_r = f_alu(fld, 1'b1);
        alu_i = f_alu(fld, 1'b0);
        case (fld[6:0])
            7'b0110011: f_class = alu_r[4] ? c_CLS_R : c_CLS_BAD;
            7'b0010011: f_class = alu_i[4] ? c_CLS_I : c_CLS_BAD;
            7'b0000011: f_class = (fld[9:7] == 3'b010) ? c_CLS_LD : c_CLS_BAD;
            7'b0100011: f_class = (fld[9:7] == 3'b010) ? c_CLS_ST : c_CLS_BAD;
            7'b1100011: f_class = (fld[9:8] == 2'b00) ? c_CLS_BR : c_CLS_BAD;
            default:    f_class = c_CLS_BAD;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [10:0]      r_instr;
    logic             r_halt;
    logic [CNT_W-1:0] r_retired;

    logic [10:0] w_fields;
    logic [2:0]  w_dec_cls;
    logic [2:0]  w_cls;
    logic [4:0]  w_alu;
    logic        w_taken;
    logic        w_unused_bits;

    logic       w_pc_en;
    logic       w_pcsrc;
    logic       w_alusrc;
    logic [3:0] w_aluop;
    logic       w_memrw;
    logic       w_wb;
    logic       w_regrw;
    logic [1:0] w_immgen;
    logic       w_done;

    assign w_fields      = {bus.instr[30], bus.instr[14:12], bus.instr[6:0]};
    assign w_unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7], bus.status[3:0]};
    assign w_dec_cls     = f_class(w_fields);
    assign w_cls         = f_class(r_instr);
    assign w_alu         = f_alu(r_instr, (w_cls == c_CLS_R));
    // funct3[0] distinguishes BNE from BEQ
    assign w_taken       = r_instr[7] ? ~bus.status[4] : bus.status[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_instr   <= '0;
            r_halt    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_instr <= w_fields;
            end
            if (w_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_next == ST_TRAP) begin
                r_halt <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_pc_en  = 1'b0;
        w_pcsrc  = 1'b0;
        w_alusrc = 1'b0;
        w_aluop  = c_OP_ADD;
        w_memrw  = 1'b0;
        w_wb     = 1'b1;
        w_regrw  = 1'b0;
        w_immgen = 2'b00;
        w_done   = 1'b0;

        // Datapath selects stay constant from EXEC through MEM and WB
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            case (w_cls)
                c_CLS_R:  begin w_alusrc = 1'b0; w_immgen = 2'b00; w_aluop = w_alu[3:0]; end
                c_CLS_I:  begin w_alusrc = 1'b1; w_immgen = 2'b01; w_aluop = w_alu[3:0]; end
                c_CLS_LD: begin w_alusrc = 1'b1; w_immgen = 2'b01; w_aluop = c_OP_ADD;   end
                c_CLS_ST: begin w_alusrc = 1'b1; w_immgen = 2'b10; w_aluop = c_OP_ADD;   end
                c_CLS_BR: begin w_alusrc = 1'b0; w_immgen = 2'b11; w_aluop = c_OP_SUB;   end
                default:  begin w_alusrc = 1'b0; w_immgen = 2'b00; w_aluop = c_OP_ADD;   end
            endcase
        end

        case (r_state)
            ST_FETCH: begin
                if (bus.run) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = (w_dec_cls == c_CLS_BAD) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (w_cls)
                    c_CLS_R, c_CLS_I:   w_next = ST_WB;
                    c_CLS_LD, c_CLS_ST: w_next = ST_MEM;
                    c_CLS_BR: begin
                        w_pcsrc = w_taken;
                        w_pc_en = 1'b1;
                        w_done  = 1'b1;
                        w_next  = ST_FETCH;
                    end
                    default:            w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (w_cls == c_CLS_ST) begin
                    w_memrw = 1'b1;
                    w_pc_en = 1'b1;
                    w_done  = 1'b1;
                    w_next  = ST_FETCH;
                end else begin
                    w_next  = ST_WB;
                end
            end
            ST_WB: begin
                w_regrw = 1'b1;
                w_wb    = (w_cls != c_CLS_LD);
                w_pc_en = 1'b1;
                w_done  = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_TRAP: begin
                w_next = ST_TRAP;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.pcsrc       = w_pcsrc;
    assign bus.alusrc      = w_alusrc;
    assign bus.aluop       = w_aluop;
    assign bus.memrw       = w_memrw;
    assign bus.wb          = w_wb;
    assign bus.regrw       = w_regrw;
    assign bus.immgen_ctrl = w_immgen;
    assign bus.halt        = r_halt;
    assign bus.done        = w_done;
    assign bus.state       = r_state;
    assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [31:0] c_ADD  = 32'h002081B3;
    localparam logic [31:0] c_SUB  = 32'h402081B3;
    localparam logic [31:0] c_SRAI = 32'h4020D193;
    localparam logic [31:0] c_LW   = 32'h0000A283;
    localparam logic [31:0] c_SW   = 32'h0020A223;
    localparam logic [31:0] c_BEQ  = 32'h00208463;
    localparam logic [31:0] c_BNE  = 32'h00209463;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    multicycle_ctrl_if #(.CNT_W(16)) bus  ();
    multicycle_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus2.run    = bus.run;
    assign bus2.instr  = bus.instr;
    assign bus2.status = bus.status;

    multicycle_ctrl #(.CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus.master));
    multicycle_ctrl #(.CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: present the instruction with run=1 and step into DECODE
    task automatic issue(input logic [31:0] ins);
        bus.instr = ins;
        bus.run   = 1'b1;
        tick();
        bus.run   = 1'b0;
    endtask

    // Leave DECODE; scramble instr afterwards to show controls use the latched copy
    task automatic to_exec();
        tick();
        bus.instr = 32'h0;
    endtask

    initial begin
        int hold_bad;
        int trap_en;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        bus.run    = 1'b0;
        bus.instr  = 32'h0;
        bus.status = 5'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_state", bus.state, 0);
        check("rst_halt", bus.halt, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_enables", {bus.pc_en, bus.memrw, bus.regrw, bus.done}, 0);
        check("rst_selects", {bus.pcsrc, bus.alusrc, bus.aluop, bus.immgen_ctrl}, 0);
        check("rst_wb", bus.wb, 1);

        // ADD: 0,1,2,4,0
        issue(c_ADD);
        check("add_dec_state", bus.state, 1);
        to_exec();
        check("add_ex_state", bus.state, 2);
        check("add_ex_aluop", bus.aluop, 4'b0000);
        check("add_ex_alusrc", bus.alusrc, 0);
        check("add_ex_en", {bus.pc_en, bus.regrw, bus.memrw, bus.done}, 0);
        tick();
        check("add_wb_state", bus.state, 4);
        check("add_wb_ctl", {bus.regrw, bus.wb, bus.pc_en, bus.pcsrc, bus.done, bus.memrw}, 6'b111010);
        tick();
        check("add_fetch_state", bus.state, 0);
        check("add_retired", bus.retired, 1);

        // run=0 holds FETCH
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.state != 3'd0 || bus.pc_en) hold_bad++;
        end
        check("hold_fetch", hold_bad, 0);

        // LW: 0,1,2,3,4,0
        issue(c_LW);
        to_exec();
        check("lw_ex", {bus.state, bus.immgen_ctrl, bus.alusrc, bus.aluop, bus.memrw}, {3'd2, 2'b01, 1'b1, 4'd0, 1'b0});
        tick();
        check("lw_mem", {bus.state, bus.immgen_ctrl, bus.alusrc, bus.memrw, bus.regrw, bus.pc_en}, {3'd3, 2'b01, 1'b1, 3'b000});
        tick();
        check("lw_wb", {bus.state, bus.regrw, bus.wb, bus.pc_en, bus.done, bus.memrw}, {3'd4, 5'b10110});
        tick();
        check("lw_retired", {bus.state, bus.retired}, {3'd0, 16'd2});

        // SW: 0,1,2,3,0
        issue(c_SW);
        to_exec();
        check("sw_ex", {bus.state, bus.immgen_ctrl, bus.alusrc, bus.memrw, bus.regrw}, {3'd2, 2'b10, 1'b1, 2'b00});
        tick();
        check("sw_mem", {bus.state, bus.memrw, bus.regrw, bus.pc_en, bus.pcsrc, bus.done}, {3'd3, 5'b10101});
        tick();
        check("sw_after", {bus.state, bus.memrw, bus.retired}, {3'd0, 1'b0, 16'd3});

        // BEQ taken / not taken, BNE taken
        issue(c_BEQ);
        bus.status = 5'b10000;
        to_exec();
        check("beq_z1", {bus.state, bus.pcsrc, bus.pc_en, bus.aluop, bus.immgen_ctrl, bus.done, bus.alusrc}, {3'd2, 2'b11, 4'd1, 2'b11, 2'b10});
        tick();
        check("beq_z1_ret", {bus.state, bus.retired}, {3'd0, 16'd4});

        issue(c_BEQ);
        bus.status = 5'b00000;
        to_exec();
        check("beq_z0", {bus.pcsrc, bus.pc_en, bus.done}, 3'b011);
        tick();
        check("beq_z0_ret", {bus.state, bus.retired}, {3'd0, 16'd5});

        issue(c_BNE);
        bus.status = 5'b01111;
        to_exec();
        check("bne_z0", {bus.pcsrc, bus.pc_en}, 2'b11);
        tick();

        // SUB and SRAI aluop decode
        issue(c_SUB);
        to_exec();
        check("sub_ex", {bus.aluop, bus.alusrc}, {4'b0001, 1'b0});
        tick();
        tick();
        issue(c_SRAI);
        to_exec();
        check("srai_ex", {bus.aluop, bus.alusrc, bus.immgen_ctrl}, {4'b0111, 1'b1, 2'b01});
        tick();
        check("srai_wb", {bus.state, bus.wb, bus.regrw}, {3'd4, 2'b11});
        tick();
        check("retired_8", bus.retired, 8);

        // Illegal instruction traps and stays trapped with run held high
        issue(32'h0);
        tick();
        check("trap_state", {bus.state, bus.halt}, {3'd5, 1'b1});
        bus.run = 1'b1;
        trap_en = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.pc_en || bus.regrw || bus.memrw || bus.done) trap_en++;
        end
        check("trap_hold", {bus.state, bus.halt}, {3'd5, 1'b1});
        check("trap_enables", trap_en, 0);
        check("trap_retired", bus.retired, 8);
        bus.run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("trap_rst", {bus.state, bus.halt, bus.retired}, {3'd0, 1'b0, 16'd0});

        // Reset during MEM of a store aborts it
        issue(c_SW);
        to_exec();
        tick();
        check("swr_mem", {bus.state, bus.memrw}, {3'd3, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("swr_abort", {bus.state, bus.memrw, bus.retired}, {3'd0, 1'b0, 16'd0});

        // Narrow counter wraps 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            issue(c_ADD);
            to_exec();
            tick();
            tick();
            check($sformatf("wrap_%0d", i), bus2.retired, i % 4);
        end
        check("wide_4", bus.retired, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
